cam_match_sequencer: RTL and testbench
======================================

Name: cam_match_sequencer

Overview:
- Sits directly upstream of the CAM read-data mux and drives its 5-bit select.
- Takes the 32-bit match-line vector produced by a CAM search and captures it.
- Emits one select beat per matching entry, lowest index first, over a valid/ready handshake. The mux uses each beat to return that entry's data word.
- A search with no matching entry produces a single miss beat.

Parameters:
- ENTRIES, 32, number of CAM entries / match lines; must equal mux input count.
- IDX_W, 5, select width; must equal $clog2(ENTRIES).
- CNT_W, 6, match-count width; must equal $clog2(ENTRIES+1).

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- match_valid_i  input  1  match vector valid.
- match_ready_o  output  1  block can accept a new match vector.
- match_i  input  ENTRIES  match lines; bit k set = entry k matched.
- flush_i  input  1  synchronous abort of the search in progress.
- sel_valid_o  output  1  select beat valid.
- sel_ready_i  input  1  downstream accepts beat.
- select_o  output  IDX_W  entry index for the mux.
- hit_o  output  1  1 = select_o is a real match; 0 = miss beat.
- last_o  output  1  final beat of the current search.

Behaviour:
- Reset (async assert, sync deassert handled externally):
  - state=IDLE; pending=0.
  - match_ready_o=1, sel_valid_o=0, select_o=0, hit_o=0, last_o=0.
- State IDLE:
  - match_ready_o=1, sel_valid_o=0.
  - On match_valid_i: latch match_i into pending and go to EMIT.
  - First beat is visible the next cycle, so capture-to-beat latency is 1 cycle.
- State EMIT:
  - match_ready_o=0; sel_valid_o=1.
  - All outputs are registered and held stable while sel_ready_i=0.
  - pending!=0: select_o = index of lowest set bit, hit_o=1, last_o=1 when exactly one bit remains.
  - pending==0 at capture (miss): select_o=0, hit_o=0, last_o=1.
  - On sel_ready_i with last_o=0: clear the lowest set bit; the next beat is presented the following cycle.
    - Throughput is 1 beat/cycle when sel_ready_i is held high.
  - On sel_ready_i with last_o=1: return to IDLE; match_ready_o=1 the next cycle.
    - No back-to-back overlap: at least one IDLE cycle between searches.
- Index encoding:
  - Priority encoder over pending; lowest index wins.
  - Bit ENTRIES-1 maps to select_o=ENTRIES-1 (31).
  - No wrap-around.
- flush_i:
  - Highest priority in any state: next cycle state=IDLE, pending=0, sel_valid_o=0.
  - flush_i together with match_valid_i in IDLE: the vector is dropped.
  - flush_i together with sel_ready_i: the beat counts as transferred, but no further beats follow.
- match_valid_i while match_ready_o=0: ignored; the upstream must hold it.
- Reset mid-search: all state is discarded immediately; outputs take reset values asynchronously.
- All-ones vector: exactly 32 beats, select 0..31, last_o only on 31.

Optional Feature:
- Macro: CAM_MATCH_COUNT_EN.
- When defined:
  - Adds output port match_count_o (CNT_W), the popcount of the captured vector.
  - Registered at capture and held until the next capture.
  - Reset value 0; flush clears it to 0.
  - A miss shows 0; all-ones shows 32.
- When undefined: the port and popcount logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then match_i=32'h0000_0000 captured → one beat: hit_o=0, select_o=0, last_o=1. match_ready_o returns 1 after acceptance.
- match_i=32'h8000_0011, sel_ready_i=1 → beats select 0, 4, 31 on consecutive cycles, hit_o=1; last_o only on 31.
- match_i=32'h0000_0006 with sel_ready_i low for 3 cycles → select_o=1 held stable with sel_valid_o=1. After ready: select 2, last_o=1.
- match_i=32'hFFFF_FFFF → 32 beats, select 0..31 in order. With CAM_MATCH_COUNT_EN, match_count_o=32 throughout.
- Capture 32'h0000_F000, accept first beat (12), assert flush_i → IDLE next cycle, sel_valid_o=0, no beats 13–15. A new vector 32'h1 then yields select 0.
- Deassert rst_n during beat 2 of 32'h0000_00FF → sel_valid_o=0 and match_ready_o=1 immediately. After release, 32'h0000_0100 yields select 8 only.

Source files
------------

// File: rtl/cam_match_sequencer.sv
// cam_match_sequencer
//   Captures a CAM match-line vector and walks it lowest index first, emitting
//   one mux-select beat per matching entry. A search with no match produces a
//   single miss beat (hit_o=0, last_o=1).
//
//   Handshakes (both sides): a transfer happens on a rising clk edge where
//   valid and ready are both high. A producer holds its payload stable while
//   valid is high and ready is low; valid is never withdrawn before transfer.
//
//   Optional build macro: CAM_MATCH_COUNT_EN adds match_count_o, the popcount
//   of the captured vector, registered at capture and cleared by flush/reset.
module cam_match_sequencer #(
  parameter int ENTRIES = 32,
  parameter int IDX_W   = 5,
  parameter int CNT_W   = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               match_valid_i,
  output logic               match_ready_o,
  input  logic [ENTRIES-1:0] match_i,
  input  logic               flush_i,
  output logic               sel_valid_o,
  input  logic               sel_ready_i,
  output logic [IDX_W-1:0]   select_o,
  output logic               hit_o,
  output logic               last_o
`ifdef CAM_MATCH_COUNT_EN
  ,
  output logic [CNT_W-1:0]   match_count_o
`endif
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  // Current FSM state; kept as a named enum so checkers can bind to it.
  state_t             state;
  logic [ENTRIES-1:0] pending;

  // Beat source: the incoming vector at capture, or pending with its lowest
  // set bit removed when a non-final beat is accepted.
  logic [ENTRIES-1:0] pending_cleared;
  logic [ENTRIES-1:0] beat_src;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [ENTRIES-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int k = ENTRIES - 1; k >= 0; k--) begin
      if (v[k]) idx = IDX_W'(k);
    end
    return idx;
  endfunction

  // True when zero or one bit is set: the beat built from v is the final one.
  function automatic logic at_most_one(input logic [ENTRIES-1:0] v);
    return (v & (v - ENTRIES'(1))) == '0;
  endfunction

`ifdef CAM_MATCH_COUNT_EN
  function automatic logic [CNT_W-1:0] pop_count(input logic [ENTRIES-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int k = 0; k < ENTRIES; k++) begin
      n = n + CNT_W'(v[k]);
    end
    return n;
  endfunction
`endif

  // Select the vector the next beat's registered outputs are derived from.
  always_comb begin
    pending_cleared = pending & (pending - ENTRIES'(1));
    beat_src        = (state == ST_IDLE) ? match_i : pending_cleared;
  end

  // Sequencer FSM with registered handshake and beat outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      pending       <= '0;
      match_ready_o <= 1'b1;
      sel_valid_o   <= 1'b0;
      select_o      <= '0;
      hit_o         <= 1'b0;
      last_o        <= 1'b0;
`ifdef CAM_MATCH_COUNT_EN
      match_count_o <= '0;
`endif
    end else if (flush_i) begin
      // Abort wins over everything, including a capture or an accepted beat.
      state         <= ST_IDLE;
      pending       <= '0;
      match_ready_o <= 1'b1;
      sel_valid_o   <= 1'b0;
      select_o      <= '0;
      hit_o         <= 1'b0;
      last_o        <= 1'b0;
`ifdef CAM_MATCH_COUNT_EN
      match_count_o <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (match_valid_i) begin
            state         <= ST_EMIT;
            pending       <= match_i;
            match_ready_o <= 1'b0;
            sel_valid_o   <= 1'b1;
            select_o      <= lowest_idx(beat_src);
            hit_o         <= |beat_src;
            last_o        <= at_most_one(beat_src);
`ifdef CAM_MATCH_COUNT_EN
            match_count_o <= pop_count(match_i);
`endif
          end
        end
        ST_EMIT: begin
          if (sel_ready_i) begin
            if (last_o) begin
              // Final beat taken; one IDLE cycle always separates searches.
              state         <= ST_IDLE;
              pending       <= '0;
              match_ready_o <= 1'b1;
              sel_valid_o   <= 1'b0;
              select_o      <= '0;
              hit_o         <= 1'b0;
              last_o        <= 1'b0;
            end else begin
              pending  <= pending_cleared;
              select_o <= lowest_idx(beat_src);
              hit_o    <= 1'b1;
              last_o   <= at_most_one(beat_src);
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cam_match_sequencer.sv
// Self-checking bench for cam_match_sequencer. Expected beats are derived
// from each driven vector and queued; a monitor pops and compares on every
// accepted beat. Build with +define+CAM_MATCH_COUNT_EN to cover the count.
module tb_cam_match_sequencer;

  localparam int ENTRIES = 32;
  localparam int IDX_W   = 5;
  localparam int CNT_W   = 6;

  logic               clk;
  logic               rst_n;
  logic               match_valid_i;
  logic               match_ready_o;
  logic [ENTRIES-1:0] match_i;
  logic               flush_i;
  logic               sel_valid_o;
  logic               sel_ready_i;
  logic [IDX_W-1:0]   select_o;
  logic               hit_o;
  logic               last_o;
`ifdef CAM_MATCH_COUNT_EN
  logic [CNT_W-1:0]   match_count_o;
  logic [CNT_W-1:0]   exp_count;
`endif

  int tests  = 0;
  int errors = 0;

  // Expected beat = {hit, last, select}
  logic [IDX_W+1:0] exp_q[$];

  cam_match_sequencer #(
    .ENTRIES(ENTRIES),
    .IDX_W  (IDX_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .match_valid_i(match_valid_i),
    .match_ready_o(match_ready_o),
    .match_i      (match_i),
    .flush_i      (flush_i),
    .sel_valid_o  (sel_valid_o),
    .sel_ready_i  (sel_ready_i),
    .select_o     (select_o),
    .hit_o        (hit_o),
    .last_o       (last_o)
`ifdef CAM_MATCH_COUNT_EN
    ,
    .match_count_o(match_count_o)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && sel_valid_o && sel_ready_i) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {25'd0, hit_o, last_o, select_o}, 32'hFFFF_FFFF);
      end else begin
        check("beat", {25'd0, hit_o, last_o, select_o}, {25'd0, exp_q.pop_front()});
`ifdef CAM_MATCH_COUNT_EN
        check("match_count", {26'd0, match_count_o}, {26'd0, exp_count});
`endif
      end
    end
  end

  // ---------------- drivers ----------------
  // Called at posedge+1. Waits for match_ready_o, presents vec for one edge,
  // and queues up to max_beats expected beats.
  task automatic send_vector(input logic [ENTRIES-1:0] vec, input int max_beats);
    int waited;
    int remaining;
    int n;
    waited = 0;
    while (!match_ready_o) begin
      @(posedge clk); #1;
      waited++;
      if (waited > 200) begin
        check("ready_timeout", {31'd0, match_ready_o}, 32'd1);
        return;
      end
    end
    match_valid_i = 1'b1;
    match_i       = vec;
    if (vec == '0) begin
      if (max_beats > 0) exp_q.push_back({1'b0, 1'b1, 5'd0});
    end else begin
      remaining = $countones(vec);
      n = 0;
      for (int k = 0; k < ENTRIES; k++) begin
        if (vec[k]) begin
          remaining--;
          if (n < max_beats) exp_q.push_back({1'b1, remaining == 0, 5'(k)});
          n++;
        end
      end
    end
`ifdef CAM_MATCH_COUNT_EN
    exp_count = CNT_W'($countones(vec));
`endif
    @(posedge clk); #1;
    match_valid_i = 1'b0;
    match_i       = $urandom;
  endtask

  // Runs until the scoreboard is empty and no beat is on offer.
  task automatic drain(input int budget, input bit rnd_ready, output int cycles);
    cycles = 0;
    forever begin
      @(posedge clk); #1;
      cycles++;
      if (exp_q.size() == 0 && !sel_valid_o) break;
      if (rnd_ready) sel_ready_i = 1'($urandom_range(0, 1));
      if (cycles >= budget) begin
        check("drain_timeout", exp_q.size(), 32'd0);
        exp_q.delete();
        break;
      end
    end
    sel_ready_i = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    logic [ENTRIES-1:0] rv;
    rst_n         = 1'b0;
    match_valid_i = 1'b0;
    match_i       = '0;
    flush_i       = 1'b0;
    sel_ready_i   = 1'b1;
`ifdef CAM_MATCH_COUNT_EN
    exp_count     = '0;
`endif

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_match_ready", {31'd0, match_ready_o}, 32'd1);
    check("rst_sel_valid",   {31'd0, sel_valid_o},   32'd0);
    check("rst_select",      {27'd0, select_o},      32'd0);
    check("rst_hit_last",    {30'd0, hit_o, last_o}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Miss: single beat, hit=0, last=1
    send_vector(32'h0000_0000, 99);
    drain(50, 1'b0, cyc);
    check("miss_cycles", cyc, 32'd1);
    check("miss_ready_back", {31'd0, match_ready_o}, 32'd1);

    // Three hits on consecutive cycles
    send_vector(32'h8000_0011, 99);
    drain(50, 1'b0, cyc);
    check("three_hit_cycles", cyc, 32'd3);

    // Back-pressure holds the first beat stable
    sel_ready_i = 1'b0;
    send_vector(32'h0000_0006, 99);
    repeat (3) begin
      @(negedge clk);
      check("stall_valid",  {31'd0, sel_valid_o},   32'd1);
      check("stall_select", {27'd0, select_o},      32'd1);
      check("stall_hitlast",{30'd0, hit_o, last_o}, 32'd2);
    end
    @(posedge clk); #1;
    sel_ready_i = 1'b1;
    drain(50, 1'b0, cyc);

    // All-ones: 32 beats back to back
    send_vector(32'hFFFF_FFFF, 99);
    drain(100, 1'b0, cyc);
    check("all_ones_cycles", cyc, 32'd32);

    // Flush after the first beat of 0x0000_F000
    send_vector(32'h0000_F000, 1);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    @(negedge clk);
    check("flush_sel_valid",   {31'd0, sel_valid_o},   32'd0);
    check("flush_match_ready", {31'd0, match_ready_o}, 32'd1);
`ifdef CAM_MATCH_COUNT_EN
    check("flush_count", {26'd0, match_count_o}, 32'd0);
`endif
    repeat (3) @(posedge clk);
    #1;
    check("flush_no_beats", {31'd0, sel_valid_o}, 32'd0);
    send_vector(32'h0000_0001, 99);
    drain(50, 1'b0, cyc);
    check("post_flush_cycles", cyc, 32'd1);

    // Flush together with a capture drops the vector
    match_valid_i = 1'b1;
    match_i       = 32'h0000_0040;
    flush_i       = 1'b1;
    @(posedge clk); #1;
    match_valid_i = 1'b0;
    flush_i       = 1'b0;
    @(negedge clk);
    check("flush_capture_dropped", {31'd0, sel_valid_o}, 32'd0);

    // Reset while the second beat of 0x0000_00FF is on offer
    send_vector(32'h0000_00FF, 1);
    @(posedge clk); #1;
    sel_ready_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_sel_valid",   {31'd0, sel_valid_o},   32'd0);
    check("async_rst_match_ready", {31'd0, match_ready_o}, 32'd1);
    check("async_rst_select",      {27'd0, select_o},      32'd0);
`ifdef CAM_MATCH_COUNT_EN
    check("async_rst_count", {26'd0, match_count_o}, 32'd0);
`endif
    @(posedge clk); #1;
    rst_n       = 1'b1;
    sel_ready_i = 1'b1;
    @(posedge clk); #1;
    send_vector(32'h0000_0100, 99);
    drain(50, 1'b0, cyc);
    check("post_rst_cycles", cyc, 32'd1);

    // Random vectors with random back-pressure
    for (int i = 0; i < 8; i++) begin
      rv = $urandom;
      if (i % 3 == 0) rv = rv & $urandom;
      if (i == 5) rv = '0;
      send_vector(rv, 99);
      drain(400, 1'b1, cyc);
    end

    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
